// File: rtl/fp16_add_sequencer.sv
// -----------------------------------------------------------------------------
// fp16_add_sequencer
//
// Multi-cycle half-precision adder.  Operands are captured in IDLE, aligned in
// ALIGN, added/subtracted as sign-magnitude in ADD, then normalised in NORM.
// NORM makes one left shift per cycle, so a deep cancellation takes several
// cycles.  The result is presented in DONE until the consumer takes it.
// Denormal inputs are flushed to zero.  Exponent 31 is an ordinary exponent.
// Alignment and normalisation truncate.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : operands a, b are valid
//   in_ready   : block accepts operands (IDLE and not in reset)
//   a, b       : half-precision operands {sign, exp[4:0], frac[9:0]}
//   out_valid  : result is valid (DONE)
//   out_ready  : consumer accepts the result
//   result     : half-precision sum a+b
//   ovf        : result saturated to infinity
//   zero       : result is zero (exact cancel or underflow flush)
//   busy       : state is not IDLE
// -----------------------------------------------------------------------------
module fp16_add_sequencer #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        ovf,
  output logic        zero,
  output logic        busy
);

  localparam int FRAC_W = MAN_W - 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic [EXP_W:0]   EXP_SAT  = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W-1:0] SHIFT_LIM = EXP_W'(MAN_W);

  logic [2:0]       state_q,  state_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [EXP_W-1:0] exp_a_q,  exp_a_d;
  logic [EXP_W-1:0] exp_b_q,  exp_b_d;
  logic [MAN_W-1:0] man_a_q,  man_a_d;
  logic [MAN_W-1:0] man_b_q,  man_b_d;
  logic [EXP_W-1:0] exp_q,    exp_d;
  logic             sign_q,   sign_d;
  logic [MAN_W:0]   sum_q,    sum_d;
  logic [15:0]      result_q, result_d;
  logic             ovf_q,    ovf_d;
  logic             zero_q,   zero_d;

  logic [EXP_W-1:0] exp_diff;
  logic [EXP_W:0]   exp_inc;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d  = state_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    exp_a_d  = exp_a_q;
    exp_b_d  = exp_b_q;
    man_a_d  = man_a_q;
    man_b_d  = man_b_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    sum_d    = sum_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    exp_diff = '0;
    exp_inc  = {1'b0, exp_q} + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Decode; a zero exponent field flushes the mantissa (no denormals).
          sign_a_d = a[15];
          exp_a_d  = a[14 -: EXP_W];
          man_a_d  = (a[14 -: EXP_W] == '0) ? '0 : {1'b1, a[FRAC_W-1:0]};
          sign_b_d = b[15];
          exp_b_d  = b[14 -: EXP_W];
          man_b_d  = (b[14 -: EXP_W] == '0) ? '0 : {1'b1, b[FRAC_W-1:0]};
          ovf_d    = 1'b0;
          zero_d   = 1'b0;
          state_d  = S_ALIGN;
        end
      end

      S_ALIGN: begin
        // A shift of MAN_W or more would empty the mantissa anyway; clamp it
        // explicitly so the shifter never sees an oversized amount.
        if (exp_a_q >= exp_b_q) begin
          exp_diff = exp_a_q - exp_b_q;
          exp_d    = exp_a_q;
          man_b_d  = (exp_diff >= SHIFT_LIM) ? '0 : (man_b_q >> exp_diff);
        end else begin
          exp_diff = exp_b_q - exp_a_q;
          exp_d    = exp_b_q;
          man_a_d  = (exp_diff >= SHIFT_LIM) ? '0 : (man_a_q >> exp_diff);
        end
        state_d = S_ADD;
      end

      S_ADD: begin
        if (sign_a_q == sign_b_q) begin
          sum_d  = {1'b0, man_a_q} + {1'b0, man_b_q};
          sign_d = sign_a_q;
        end else if (man_a_q > man_b_q) begin
          sum_d  = {1'b0, man_a_q} - {1'b0, man_b_q};
          sign_d = sign_a_q;
        end else if (man_b_q > man_a_q) begin
          sum_d  = {1'b0, man_b_q} - {1'b0, man_a_q};
          sign_d = sign_b_q;
        end else begin
          // Exact cancellation always yields +0.
          sum_d  = '0;
          sign_d = 1'b0;
        end
        state_d = S_NORM;
      end

      S_NORM: begin
        if (sum_q == '0) begin
          result_d = '0;
          zero_d   = 1'b1;
          state_d  = S_DONE;
        end else if (sum_q[MAN_W]) begin
          // Carry out: one right shift.  Reaching the all-ones exponent
          // saturates to infinity.
          if (exp_inc >= EXP_SAT) begin
            result_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            ovf_d    = 1'b1;
          end else begin
            result_d = {sign_q, exp_inc[EXP_W-1:0], sum_q[FRAC_W:1]};
          end
          state_d = S_DONE;
        end else if (sum_q[MAN_W-1]) begin
          result_d = {sign_q, exp_q, sum_q[FRAC_W-1:0]};
          state_d  = S_DONE;
        end else if (exp_q > EXP_ONE) begin
          // One bit of left normalisation per cycle; stay in NORM.
          sum_d = sum_q << 1;
          exp_d = exp_q - 1'b1;
        end else begin
          // Would need a denormal exponent: flush to zero.
          result_d = '0;
          zero_d   = 1'b1;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every register, including the operand and result storage, is reset
  // so an aborted operation leaves nothing stale behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      exp_a_q  <= '0;
      exp_b_q  <= '0;
      man_a_q  <= '0;
      man_b_q  <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      sum_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      exp_a_q  <= exp_a_d;
      exp_b_q  <= exp_b_d;
      man_a_q  <= man_a_d;
      man_b_q  <= man_b_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_fp16_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fp16_add_sequencer
//
// Self-checking bench for fp16_add_sequencer.  Expected sums come from an
// integer reference model that works on signed magnitudes.  The accepting edge
// counts as the first edge.  With that counting, out_valid shows after 3+shifts
// further edges.
// -----------------------------------------------------------------------------
module tb_fp16_add_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        ovf;
  logic        zero;
  logic        busy;

  int n_checks = 0;
  int n_fails  = 0;

  fp16_add_sequencer #(.EXP_W(5), .MAN_W(11)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: signed integer sum of truncated-aligned mantissas, then
  // normalise.  shifts = number of single-bit left normalisations.
  function automatic void ref_add(input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] r, output logic o,
                                  output logic z, output int shifts);
    int ex, ey, mx, my, e, s, mag;
    logic neg;
    ex = int'(x[14:10]);
    ey = int'(y[14:10]);
    mx = (ex == 0) ? 0 : 1024 + int'(x[9:0]);
    my = (ey == 0) ? 0 : 1024 + int'(y[9:0]);
    if (ex >= ey) begin
      e  = ex;
      my = (ex - ey >= 11) ? 0 : (my >> (ex - ey));
    end else begin
      e  = ey;
      mx = (ey - ex >= 11) ? 0 : (mx >> (ey - ex));
    end
    s      = (x[15] ? -mx : mx) + (y[15] ? -my : my);
    neg    = (s < 0);
    mag    = neg ? -s : s;
    shifts = 0;
    o      = 1'b0;
    z      = 1'b0;
    r      = 16'h0000;
    if (mag == 0) begin
      z = 1'b1;
    end else if (mag >= 2048) begin
      mag = mag >> 1;
      e   = e + 1;
      if (e >= 31) begin
        r = {neg, 5'h1F, 10'h000};
        o = 1'b1;
      end else begin
        r = {neg, 5'(e), 10'(mag)};
      end
    end else begin
      while (mag < 1024 && e > 1) begin
        mag    = mag << 1;
        e      = e - 1;
        shifts = shifts + 1;
      end
      if (mag < 1024) z = 1'b1;
      else            r = {neg, 5'(e), 10'(mag)};
    end
  endfunction

  // Present operands for one edge; rdy reports in_ready just before the edge.
  task automatic accept_op(input logic [15:0] x, input logic [15:0] y,
                           output logic rdy);
    @(negedge clk);
    a        = x;
    b        = y;
    in_valid = 1'b1;
    rdy      = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid, bounded.
  task automatic wait_done(output int lat, output logic timed_out);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    timed_out = !out_valid;
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_checks++;
    if ({out_valid, busy, ovf, zero} !== 4'b0000) begin
      n_fails++; $display("FAIL reset_flags got v%b b%b o%b z%b want 0000", out_valid, busy, ovf, zero);
    end
    n_checks++;
    if (result !== 16'h0000) begin n_fails++; $display("FAIL reset_result got %h want 0000", result); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
  endtask

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] r;
    logic        o;
    logic        z;
    int          lat;
    string       name;
  } vec_t;

  task automatic test_directed();
    vec_t v[8];
    logic rdy, to;
    int lat;
    v[0] = '{16'h3C00, 16'h3C00, 16'h4000, 1'b0, 1'b0, 3, "one_plus_one"};
    v[1] = '{16'h3E00, 16'hBC00, 16'h3800, 1'b0, 1'b0, 4, "one_left_shift"};
    v[2] = '{16'h3C00, 16'hBC00, 16'h0000, 1'b0, 1'b1, 3, "exact_cancel"};
    v[3] = '{16'h3C00, 16'h0C00, 16'h3C00, 1'b0, 1'b0, 3, "diff_12"};
    v[4] = '{16'h7BFF, 16'h7BFF, 16'h7C00, 1'b1, 1'b0, 3, "overflow"};
    v[5] = '{16'h0401, 16'h8400, 16'h0000, 1'b0, 1'b1, 3, "underflow_flush"};
    v[6] = '{16'h0001, 16'h8002, 16'h0000, 1'b0, 1'b1, 3, "denormals"};
    v[7] = '{16'h3C01, 16'hBC00, 16'h1400, 1'b0, 1'b0, 13, "ten_shifts"};
    foreach (v[i]) begin
      accept_op(v[i].x, v[i].y, rdy);
      n_checks++;
      if (rdy !== 1'b1) begin n_fails++; $display("FAIL %s_ready got %b want 1", v[i].name, rdy); end
      wait_done(lat, to);
      n_checks++;
      if (to || lat != v[i].lat) begin
        n_fails++; $display("FAIL %s_latency got %0d (timeout %b) want %0d", v[i].name, lat, to, v[i].lat);
      end
      n_checks++;
      if ({result, ovf, zero} !== {v[i].r, v[i].o, v[i].z}) begin
        n_fails++;
        $display("FAIL %s_result got %h o%b z%b want %h o%b z%b", v[i].name, result, ovf, zero,
                 v[i].r, v[i].o, v[i].z);
      end
      handshake();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fails++; $display("FAIL %s_release got v%b r%b want v0 r1", v[i].name, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] x, y, er;
    logic eo, ez, rdy, to;
    int sh, lat, stall;
    for (int i = 0; i < 150; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      case ($urandom_range(0, 2))
        0: y = {~x[15], x[14:10], y[9:0]};                          // deep cancel
        1: y = {y[15], 5'(x[14:10] + 5'($urandom_range(0, 3))), y[9:0]};
        default: ;
      endcase
      ref_add(x, y, er, eo, ez, sh);
      accept_op(x, y, rdy);
      n_checks++;
      if (rdy !== 1'b1) begin n_fails++; $display("FAIL rand_ready it %0d got %b want 1", i, rdy); end
      wait_done(lat, to);
      n_checks++;
      if (to || lat != 3 + sh) begin
        n_fails++; $display("FAIL rand_latency %h+%h got %0d (timeout %b) want %0d", x, y, lat, to, 3 + sh);
      end
      stall = $urandom_range(0, 2);
      repeat (stall) @(posedge clk);
      #1;
      n_checks++;
      if ({result, ovf, zero} !== {er, eo, ez} || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fails++;
        $display("FAIL rand_result %h+%h got %h o%b z%b v%b r%b want %h o%b z%b v1 r0", x, y, result,
                 ovf, zero, out_valid, in_ready, er, eo, ez);
      end
      handshake();
    end
  endtask

  task automatic test_back_to_back();
    logic rdy, to;
    logic held_ok;
    int lat;
    accept_op(16'h3C00, 16'h3C00, rdy);
    wait_done(lat, to);
    n_checks++;
    if (to || result !== 16'h4000) begin n_fails++; $display("FAIL bp_first got %h want 4000", result); end
    @(negedge clk);
    a        = 16'h3E00;
    b        = 16'hBC00;
    in_valid = 1'b1;
    held_ok  = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || result !== 16'h4000 || in_ready !== 1'b0 || busy !== 1'b1) held_ok = 1'b0;
    end
    n_checks++;
    if (!held_ok) begin
      n_fails++; $display("FAIL bp_hold got v%b r%h rdy%b want v1 r4000 rdy0", out_valid, result, in_ready);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fails++; $display("FAIL bp_idle got rdy%b v%b want rdy1 v0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fails++; $display("FAIL bp_accept got busy %b want 1", busy); end
    wait_done(lat, to);
    n_checks++;
    if (to || lat != 4 || result !== 16'h3800 || ovf !== 1'b0 || zero !== 1'b0) begin
      n_fails++; $display("FAIL bp_second got %h lat %0d want 3800 lat 4", result, lat);
    end
    handshake();
  endtask

  task automatic test_reset_mid_norm();
    logic rdy, to, stale;
    int lat;
    accept_op(16'h3C01, 16'hBC00, rdy);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fails++; $display("FAIL rst_pre got busy%b v%b want busy1 v0", busy, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 16'h0000 || in_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_abort got busy%b v%b r%h rdy%b want 0 0 0000 0", busy, out_valid, result, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) stale = 1'b1;
    end
    n_checks++;
    if (stale) begin n_fails++; $display("FAIL rst_stale got activity after abort want none"); end
    accept_op(16'h3C00, 16'h3C00, rdy);
    wait_done(lat, to);
    n_checks++;
    if (to || rdy !== 1'b1 || result !== 16'h4000 || lat != 3) begin
      n_fails++; $display("FAIL rst_recover got %h lat %0d want 4000 lat 3", result, lat);
    end
    handshake();
  endtask

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'h0000;
    b         = 16'h0000;
    rst_n     = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_norm();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fp16_add_sequencer.md
FP16_ADD_SEQUENCER -- requirements
Module: fp16_add_sequencer

Interface
REQ-001 SHALL have parameter EXP_W, default 5: exponent width (fixed; other values unsupported).
REQ-002 SHALL have parameter MAN_W, default 11: mantissa width including hidden bit (fixed).
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: operands a, b valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts operands (IDLE and rst_n high).
REQ-007 SHALL have port a, input, 16: half-precision operand {sign, exp[4:0], frac[9:0]}.
REQ-008 SHALL have port b, input, 16: half-precision operand, same format.
REQ-009 SHALL have port out_valid, output, 1: result valid.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port result, output, 16: half-precision sum a+b.
REQ-012 SHALL have port ovf, output, 1: result saturated to infinity.
REQ-013 SHALL have port zero, output, 1: result is zero (exact cancel or underflow).
REQ-014 SHALL have port busy, output, 1: state not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ALIGN, ADD, NORM, DONE.
REQ-016 IDLE: in_ready=1; in_valid high at an edge captures a and b, next state ALIGN; otherwise stay.
REQ-017 Operand decode: exp==0 SHALL be treated as zero (mantissa 0, denormals flushed); else mantissa={1,frac}; exp==31 treated as an ordinary exponent (no NaN/inf handling).
REQ-018 ALIGN (1 cycle): larger exponent becomes working exponent; the smaller-exponent mantissa is shifted right by the difference (difference >=11 gives 0; shifted-out bits discarded, truncation); tie (equal exponents) shifts nothing.
REQ-019 ADD (1 cycle): equal signs give 12-bit sum ma+mb with the common sign; unequal signs give larger magnitude minus smaller, with the sign of the larger magnitude; equal magnitudes give 0 with sign 0.
REQ-020 NORM, sum==0: result 0x0000, zero=1, next DONE.
REQ-021 NORM, sum[11]=1: shift right 1 (truncate), exp+1; if new exp==31 then result={sign,5'h1F,10'h0} with ovf=1; next DONE.
REQ-022 NORM, sum[11:10]==01: result={sign,exp,sum[9:0]}, next DONE.
REQ-023 NORM, sum[11:10]==00: if exp>1, shift left 1, exp-1, stay NORM (one bit per cycle); if exp==1, flush: result 0x0000, zero=1, next DONE.
REQ-024 DONE: out_valid=1, result/ovf/zero held stable; out_valid && out_ready at an edge moves to IDLE; in_valid ignored outside IDLE.
REQ-025 Latency: out_valid SHALL rise on the 4th edge after the accepting edge, plus one edge per left shift in NORM (max 4+10).
REQ-026 Throughput: next operands accepted no earlier than the edge after the DONE handshake (in_ready is low during DONE).
REQ-027 result, ovf and zero SHALL change only on entry to DONE or on reset; ovf and zero are cleared at each new acceptance.

Reset
REQ-028 rst_n low at an edge: state IDLE, out_valid=0, result=0x0000, ovf=0, zero=0, busy=0, internal registers 0; in_ready=0 while rst_n is low.
REQ-029 Reset in any state, including mid-NORM or DONE with out_valid high, SHALL abort the operation with no result delivered.

Verification
REQ-030 0x3C00 + 0x3C00, out_ready=1 -> result 0x4000, ovf=0, zero=0, out_valid on the 4th edge after accept.
REQ-031 0x3E00 + 0xBC00 -> result 0x3800 after one left shift, out_valid on the 5th edge.
REQ-032 0x3C00 + 0xBC00 -> result 0x0000, zero=1; 0x3C00 + 0x0C00 (exp difference 12) -> result 0x3C00.
REQ-033 0x7BFF + 0x7BFF -> result 0x7C00, ovf=1.
REQ-034 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> result held, in_ready=0, no capture; out_ready=1 -> IDLE, then the new operands are accepted.
REQ-035 Assert rst_n=0 for 1 cycle during NORM -> next cycle IDLE, out_valid=0, result 0x0000, and no stale result afterwards.
